// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd
//   BCD countdown timer (MM:SS.cc, 10 ms resolution) driven by the free-running
//   100 Hz square wave from the clock divider. The square wave is synchronised
//   into the 50 MHz domain and edge-detected into one-cycle ticks. Each tick
//   decrements the time by one centisecond while running.
//
// Ports
//   CLK_50_MHz    in   system clock
//   reset_n       in   asynchronous active-low reset
//   clk_100hz_in  in   100 Hz square wave (asynchronous data, never a clock)
//   load          in   one-cycle pulse: load load_value (MM:SS, cc = 00)
//   load_value    in   {min_tens, min_units, sec_tens, sec_units} BCD
//   start_stop    in   one-cycle pulse: toggle run/pause
//   time_bcd      out  {m_t, m_u, s_t, s_u, c_t, c_u}
//   running       out  high while counting
//   expired       out  high from expiry until the next accepted load
//   done          out  one-cycle pulse at expiry
//   load_err      out  one-cycle pulse when a load is rejected

module countdown_timer_bcd #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK_50_MHz,
  input  logic        reset_n,
  input  logic        clk_100hz_in,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start_stop,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        expired,
  output logic        done,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED,
    EXPIRED
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   synced;
  logic                   tick;

  logic [23:0] time_d;
  logic [23:0] dec_val;
  logic        expired_d;
  logic        done_d;
  logic        load_err_d;
  logic        load_ok;

  // ---------------------------------------------------------------------------
  // Tick recovery: synchroniser chain followed by a rising-edge detector.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_100hz_in};
      edge_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign tick   = synced & ~edge_q;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // All nibbles must be decimal digits and seconds-tens must not exceed 5.
  function automatic logic bcd_load_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (v[7:4] > 4'd5) ok = 1'b0;
    return ok;
  endfunction

  // One-centisecond BCD decrement. Digit 3 (seconds tens) wraps 0->5, all
  // others wrap 0->9; a borrow ripples upward until a nonzero digit absorbs it.
  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [23:0] r;
    logic        borrow;
    logic [3:0]  dig;
    logic [3:0]  lim;
    r      = t;
    borrow = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      dig = t[i*4 +: 4];
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (dig == 4'd0) begin
          dig = lim;
        end else begin
          dig    = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      r[i*4 +: 4] = dig;
    end
    return r;
  endfunction

  assign load_ok = bcd_load_ok(load_value);
  assign dec_val = bcd_dec(time_bcd);

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      time_bcd <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_bcd <= time_d;
      running  <= (state_d == RUNNING);
      expired  <= expired_d;
      done     <= done_d;
      load_err <= load_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    time_d     = time_bcd;
    expired_d  = expired;
    done_d     = 1'b0;
    load_err_d = 1'b0;

    case (state_q)
      RUNNING: begin
        // Pausing wins over a coincident tick; that tick is simply dropped.
        if (start_stop) begin
          state_d = PAUSED;
        end else if (tick) begin
          time_d = dec_val;
          if (dec_val == '0) begin
            state_d   = EXPIRED;
            done_d    = 1'b1;
            expired_d = 1'b1;
          end
        end
      end

      IDLE, PAUSED, EXPIRED: begin
        // A load pulse takes precedence over start_stop in the same cycle.
        if (load) begin
          if (load_ok) begin
            time_d    = {load_value, 8'h00};
            state_d   = IDLE;
            expired_d = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (start_stop && (time_bcd != '0)) begin
          state_d = RUNNING;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed testbench for countdown_timer_bcd. Each scenario task drives its
// own stimulus and compares outputs against hand-computed BCD values.

module tb_countdown_timer_bcd;

  logic        CLK_50_MHz;
  logic        reset_n;
  logic        clk_100hz_in;
  logic        load;
  logic [15:0] load_value;
  logic        start_stop;
  logic [23:0] time_bcd;
  logic        running;
  logic        expired;
  logic        done;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int d0;

  countdown_timer_bcd #(.SYNC_STAGES(2)) dut (
    .CLK_50_MHz  (CLK_50_MHz),
    .reset_n     (reset_n),
    .clk_100hz_in(clk_100hz_in),
    .load        (load),
    .load_value  (load_value),
    .start_stop  (start_stop),
    .time_bcd    (time_bcd),
    .running     (running),
    .expired     (expired),
    .done        (done),
    .load_err    (load_err)
  );

  initial CLK_50_MHz = 1'b0;
  always #10 CLK_50_MHz = ~CLK_50_MHz;

  // Counts done pulses, sampled away from the active edge.
  always @(negedge CLK_50_MHz) begin
    if (done === 1'b1) done_count <= done_count + 1;
  end

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK_50_MHz);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    step(1);
    load       = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  // One full 100 Hz period, compressed: 4 cycles high, 2 low.
  task automatic send_tick();
    clk_100hz_in = 1'b1;
    step(4);
    clk_100hz_in = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    checks++; if (time_bcd !== 24'h0) begin errors++; $display("FAIL rst_time got %h want %h", time_bcd, 24'h0); end
    checks++; if ({running, expired, done, load_err} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b want 0000", {running, expired, done, load_err}); end
    reset_n = 1'b1;
    step(3);
    checks++; if ({running, expired, done, load_err} !== 4'b0) begin errors++; $display("FAIL rst_release got %b want 0000", {running, expired, done, load_err}); end
  endtask

  task automatic test_latency();
    pulse_load(16'h0001);
    checks++; if (time_bcd !== 24'h000100) begin errors++; $display("FAIL lat_load got %h want %h", time_bcd, 24'h000100); end
    pulse_ss();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lat_run got %b want 1", running); end
    clk_100hz_in = 1'b1;
    step(1); // edge N samples the rising input
    checks++; if (time_bcd !== 24'h000100) begin errors++; $display("FAIL lat_N got %h want %h", time_bcd, 24'h000100); end
    step(1); // edge N+1
    checks++; if (time_bcd !== 24'h000100) begin errors++; $display("FAIL lat_N1 got %h want %h", time_bcd, 24'h000100); end
    step(1); // edge N+2 updates
    checks++; if (time_bcd !== 24'h000099) begin errors++; $display("FAIL lat_N2 got %h want %h", time_bcd, 24'h000099); end
    step(5);
    checks++; if (time_bcd !== 24'h000099) begin errors++; $display("FAIL lat_hold got %h want %h", time_bcd, 24'h000099); end
    clk_100hz_in = 1'b0;
    step(4);
    checks++; if (time_bcd !== 24'h000099) begin errors++; $display("FAIL lat_fall got %h want %h", time_bcd, 24'h000099); end
    pulse_ss();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL lat_pause got %b want 0", running); end
  endtask

  task automatic test_full_run();
    pulse_load(16'h0001);
    pulse_ss();
    d0 = done_count;
    repeat (99) send_tick();
    checks++; if (time_bcd !== 24'h000001) begin errors++; $display("FAIL run99_time got %h want %h", time_bcd, 24'h000001); end
    checks++; if (done_count - d0 !== 0) begin errors++; $display("FAIL run99_done got %0d want 0", done_count - d0); end
    send_tick();
    checks++; if (time_bcd !== 24'h0) begin errors++; $display("FAIL run100_time got %h want %h", time_bcd, 24'h0); end
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL run100_done got %0d want 1", done_count - d0); end
    checks++; if ({running, expired} !== 2'b01) begin errors++; $display("FAIL run100_flags got %b want 01", {running, expired}); end
    repeat (3) send_tick();
    checks++; if (time_bcd !== 24'h0 || done_count - d0 !== 1) begin errors++; $display("FAIL run_after got %h/%0d want 000000/1", time_bcd, done_count - d0); end
    pulse_ss();
    step(1);
    checks++; if ({running, expired} !== 2'b01) begin errors++; $display("FAIL ss_at_zero got %b want 01", {running, expired}); end
  endtask

  task automatic test_borrow();
    pulse_load(16'h1000);
    checks++; if ({time_bcd, expired} !== {24'h100000, 1'b0}) begin errors++; $display("FAIL brw_load got %h/%b want 100000/0", time_bcd, expired); end
    pulse_ss();
    send_tick();
    checks++; if (time_bcd !== 24'h095999) begin errors++; $display("FAIL brw_10m got %h want %h", time_bcd, 24'h095999); end
    pulse_ss();
    pulse_load(16'h0100);
    pulse_ss();
    send_tick();
    checks++; if (time_bcd !== 24'h005999) begin errors++; $display("FAIL brw_1m got %h want %h", time_bcd, 24'h005999); end
    pulse_ss();
  endtask

  task automatic test_invalid_load();
    pulse_load(16'h0160);
    checks++; if ({load_err, running, time_bcd} !== {2'b10, 24'h005999}) begin errors++; $display("FAIL inv_0160 got %b/%b/%h want 1/0/005999", load_err, running, time_bcd); end
    step(1);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL inv_pulse got %b want 0", load_err); end
    pulse_load(16'h0A00);
    checks++; if ({load_err, running, time_bcd} !== {2'b10, 24'h005999}) begin errors++; $display("FAIL inv_0A00 got %b/%b/%h want 1/0/005999", load_err, running, time_bcd); end
    step(1);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL inv_pulse2 got %b want 0", load_err); end
    pulse_ss();
    send_tick();
    checks++; if ({running, time_bcd} !== {1'b1, 24'h005998}) begin errors++; $display("FAIL inv_resume got %b/%h want 1/005998", running, time_bcd); end
    pulse_load(16'h0200);
    checks++; if ({load_err, running, time_bcd} !== {2'b01, 24'h005998}) begin errors++; $display("FAIL load_in_run got %b/%b/%h want 0/1/005998", load_err, running, time_bcd); end
    pulse_ss();
  endtask

  task automatic test_pause_priority();
    pulse_load(16'h9959);
    checks++; if (time_bcd !== 24'h995900) begin errors++; $display("FAIL max_load got %h want %h", time_bcd, 24'h995900); end
    pulse_load(16'h0100);
    pulse_ss();
    repeat (5) send_tick();
    checks++; if (time_bcd !== 24'h005995) begin errors++; $display("FAIL pp_5 got %h want %h", time_bcd, 24'h005995); end
    clk_100hz_in = 1'b1;
    step(2);          // tick is now high for the coming edge
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    checks++; if ({running, time_bcd} !== {1'b0, 24'h005995}) begin errors++; $display("FAIL pp_pause got %b/%h want 0/005995", running, time_bcd); end
    step(3);
    clk_100hz_in = 1'b0;
    step(2);
    repeat (10) send_tick();
    checks++; if (time_bcd !== 24'h005995) begin errors++; $display("FAIL pp_frozen got %h want %h", time_bcd, 24'h005995); end
    pulse_ss();
    send_tick();
    checks++; if ({running, time_bcd} !== {1'b1, 24'h005994}) begin errors++; $display("FAIL pp_resume got %b/%h want 1/005994", running, time_bcd); end
    pulse_ss();
    load       = 1'b1;
    load_value = 16'h0200;
    start_stop = 1'b1;
    step(1);
    load       = 1'b0;
    start_stop = 1'b0;
    step(1);
    checks++; if ({running, time_bcd} !== {1'b0, 24'h020000}) begin errors++; $display("FAIL pp_same_cycle got %b/%h want 0/020000", running, time_bcd); end
  endtask

  task automatic test_reset_mid_run();
    pulse_load(16'h0031);
    pulse_ss();
    repeat (50) send_tick();
    checks++; if ({running, time_bcd} !== {1'b1, 24'h003050}) begin errors++; $display("FAIL mid_pre got %b/%h want 1/003050", running, time_bcd); end
    clk_100hz_in = 1'b1;
    #5 reset_n = 1'b0;
    #1;
    checks++; if ({time_bcd, running, expired, done, load_err} !== 28'h0) begin errors++; $display("FAIL mid_async got %h want 0", {time_bcd, running, expired, done, load_err}); end
    step(2);
    reset_n = 1'b1;
    step(6);
    checks++; if ({running, time_bcd} !== 25'h0) begin errors++; $display("FAIL mid_release got %b/%h want 0/000000", running, time_bcd); end
    clk_100hz_in = 1'b0;
    step(2);
    send_tick();
    pulse_ss();
    step(1);
    checks++; if ({running, time_bcd} !== 25'h0) begin errors++; $display("FAIL mid_after got %b/%h want 0/000000", running, time_bcd); end
  endtask

  initial begin
    reset_n      = 1'b0;
    clk_100hz_in = 1'b0;
    load         = 1'b0;
    load_value   = 16'h0;
    start_stop   = 1'b0;
    test_reset();
    test_latency();
    test_full_run();
    test_borrow();
    test_invalid_load();
    test_pause_priority();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Consumer end of the 100 Hz divided-clock interface. Takes the free-running 100 Hz square wave as a level input and recovers one-cycle 50 MHz-domain ticks from it.
- Uses those ticks to run a BCD countdown timer (MM:SS.cc, 10 ms resolution) with load, start/stop and expiry. This is the timer counterpart of the stopwatch.
- Drives the 7-segment decode path and the buzzer/LED expiry logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on clk_100hz_in (minimum 2).

Ports:
- CLK_50_MHz  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- clk_100hz_in  in  1  100 Hz square wave from the divider; treated as asynchronous data, never used as a clock.
- load  in  1  one-cycle pulse; load load_value.
- load_value  in  16  BCD {min_tens, min_units, sec_tens, sec_units}; centiseconds are loaded as 00.
- start_stop  in  1  one-cycle pulse; toggles run/pause.
- time_bcd  out  24  {m_t, m_u, s_t, s_u, c_t, c_u}, 4 bits each.
- running  out  1  high while counting.
- expired  out  1  level; high from expiry until the next accepted load.
- done  out  1  one-cycle pulse at expiry.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset values (async assert, sync release):
  - time_bcd = 0, running = 0, expired = 0, done = 0, load_err = 0.
  - FSM = IDLE.
  - All sync flops and the edge register = 0.
- Tick recovery:
  - clk_100hz_in passes through SYNC_STAGES flops, then an edge register.
  - tick = synced & ~edge_reg.
  - With SYNC_STAGES = 2, a rising input sampled at edge N produces a counter update at edge N+2, i.e. the 3rd rising clock edge including the sampling edge.
  - Exactly one tick per input rising edge. Falling edges are ignored.
- FSM states: IDLE, RUNNING, PAUSED, EXPIRED.
  - IDLE / PAUSED / EXPIRED, on start_stop:
    - If time_bcd != 0, go to RUNNING.
    - If time_bcd == 0, ignore it and stay in the current state.
  - RUNNING, on start_stop: go to PAUSED; any tick in the same cycle is discarded.
  - RUNNING, on tick: decrement once. If the result is 0, go to EXPIRED, pulse done for 1 cycle and set expired = 1.
  - IDLE / PAUSED / EXPIRED, on accepted load: time_bcd = {load_value, 8'h00}, go to IDLE, clear expired.
  - RUNNING: load is ignored. No load_err, no change.
- running = 1 iff the state is RUNNING; it is registered and changes on the same edge as the state.
- Load validation:
  - A load is rejected if any nibble is > 9 or sec_tens > 5.
  - On rejection: load_err pulses for 1 cycle; state and time are unchanged.
  - Load of 00:00 is accepted (time = 0, state IDLE).
- Same-cycle priority: load and start_stop together in a non-running state means the load is taken and start_stop is ignored.
- Decrement (BCD borrow chain):
  - c_u 0→9 borrows from c_t; c_t 0→9 borrows from s_u.
  - s_u 0→9 borrows from s_t; s_t 0→5 borrows from m_u.
  - m_u 0→9 borrows from m_t.
  - Maximum value 99:59.99. A decrement from 0 never occurs: expiry is taken at the transition to 0.
- Ticks outside RUNNING are discarded; they are not accumulated.
- Reset mid-operation: everything returns to the reset values immediately and any pending tick is lost. If clk_100hz_in is high at reset release, one tick is generated about 3 cycles later; it has no effect because the state is IDLE.
- done and load_err are registered outputs.

Test Plan:
- Latency: load 00:01, start; raise clk_100hz_in just before edge N -> time_bcd updates from 00:01.00 to 00:00.99 at edge N+2, with no second update while the input stays high.
- Full run: load 00:01, start, apply 100 input periods -> done pulses once on the 100th tick, time_bcd = 0, expired = 1, running = 0; further ticks cause no change.
- Borrow chain: load 10:00, start, 1 tick -> time_bcd = 09:59.99; load 01:00 then 1 tick -> 00:59.99.
- Invalid load: load_value = 16'h0160 -> load_err pulses 1 cycle, time and state unchanged. load_value = 16'h0A00 -> same result.
- Pause/priority:
  - Run 5 ticks, then assert start_stop on a tick cycle -> the value is frozen with that tick discarded; 10 more ticks cause no change.
  - Resume -> decrement continues.
  - A load pulse during RUNNING is ignored.
  - start_stop at time 0 is ignored.
- Reset mid-run: assert reset_n low while RUNNING at 00:30.50 -> all outputs are 0 and the state is IDLE; after release, ticks do not change time_bcd.
